// File: rtl/lod_pred_arb.sv
// lod_pred_arb: round-robin arbiter that shares one leading-one predictor
// (pre_sum) between NUM_REQ adder lanes. Each transaction takes one operand
// pair and returns the predicted vector c = carry | a | b, its leading-one
// position, a zero flag and the requester ID.
module lod_pred_arb #(
  parameter int BUS_WIDTH = 11,
  parameter int NUM_REQ   = 2,
  parameter int IDW       = $clog2(NUM_REQ),
  parameter int LW        = $clog2(BUS_WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [IDW-1:0]               res_id,
  output logic [BUS_WIDTH:0]           res_vec,
  output logic [LW-1:0]                res_lod,
  output logic                         res_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       grant_id;
  logic [IDW-1:0]       cand;
  logic                 grant_any;
  logic                 accept;
  logic [BUS_WIDTH-1:0] op_a;
  logic [BUS_WIDTH-1:0] op_b;
  logic [IDW-1:0]       op_id;
  logic [BUS_WIDTH:0]   carry;
  logic                 carry_run;
  logic [BUS_WIDTH:0]   pred;
  logic [LW-1:0]        lod_pos;
  logic                 pred_zero;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // Reset gates acceptance so nothing is granted while rst_n is low.
  assign accept = (state == IDLE) && rst_n && grant_any;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> CALC on accept, CALC -> DONE, DONE -> IDLE on res_ready.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: one-hot grant only in IDLE, result valid only in DONE.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    res_valid = (state == DONE);
  end

  // Carry chain of the predictor; the final carry lands in the top bit of c.
  always_comb begin
    carry     = '0;
    carry_run = 1'b0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      carry[i]  = carry_run;
      carry_run = (op_a[i] & op_b[i]) | (op_a[i] & carry_run) | (op_b[i] & carry_run);
    end
    carry[BUS_WIDTH] = carry_run;
    pred = carry | {1'b0, op_a} | {1'b0, op_b};
  end

  // Leading-one encoder: highest set bit wins, zero vector encodes as 0.
  always_comb begin
    lod_pos = '0;
    for (int i = 0; i <= BUS_WIDTH; i++) begin
      if (pred[i]) lod_pos = LW'(i);
    end
    pred_zero = ~|pred;
  end

  // Operand capture, round-robin pointer and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
      res_id   <= '0;
      res_vec  <= '0;
      res_lod  <= '0;
      res_zero <= 1'b0;
    end else begin
      if (accept) begin
        op_a  <= req_a[grant_id*BUS_WIDTH +: BUS_WIDTH];
        op_b  <= req_b[grant_id*BUS_WIDTH +: BUS_WIDTH];
        op_id <= grant_id;
        if (int'(grant_id) == NUM_REQ - 1) ptr <= '0;
        else                               ptr <= grant_id + 1'b1;
      end
      if (state == CALC) begin
        res_id   <= op_id;
        res_vec  <= pred;
        res_lod  <= lod_pos;
        res_zero <= pred_zero;
      end
    end
  end

endmodule

// File: tb/tb_lod_pred_arb.sv
// tb_lod_pred_arb: scenario-based bench for lod_pred_arb with an arithmetic
// reference model of the predictor and a round-robin grant model.
module tb_lod_pred_arb;

  localparam int BW  = 11;
  localparam int N   = 2;
  localparam int IDW = 1;
  localparam int LW  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*BW-1:0]   req_a = '0;
  logic [N*BW-1:0]   req_b = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [IDW-1:0]    res_id;
  logic [BW:0]       res_vec;
  logic [LW-1:0]     res_lod;
  logic              res_zero;

  int total = 0;
  int bad   = 0;
  int mptr  = 0;

  lod_pred_arb #(.BUS_WIDTH(BW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_vec(res_vec), .res_lod(res_lod), .res_zero(res_zero)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // c = carry | a | b, with the carry vector taken from a real addition: (a+b)^a^b.
  function automatic logic [BW:0] model_vec(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW:0] s;
    logic [BW:0] cy;
    s  = {1'b0, a} + {1'b0, b};
    cy = s ^ {1'b0, a} ^ {1'b0, b};
    return cy | {1'b0, a} | {1'b0, b};
  endfunction

  // Highest set index via floor(log2(c)).
  function automatic logic [LW-1:0] model_lod(input logic [BW:0] c);
    if (c == 0) return '0;
    return LW'($clog2(int'(c) + 1) - 1);
  endfunction

  // First valid requester searching cyclically from p; -1 when none.
  function automatic int model_grant(input logic [N-1:0] mask, input int p);
    for (int i = 0; i < N; i++) begin
      if (mask[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL reset_ready_low: got %b want 0", req_ready); end
    @(negedge clk);
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_res_valid: got %b want 0", res_valid); end
    total++; if (res_vec !== '0) begin bad++; $display("[TB] FAIL reset_res_vec: got %h want 0", res_vec); end
    total++; if (res_lod !== '0) begin bad++; $display("[TB] FAIL reset_res_lod: got %0d want 0", res_lod); end
    total++; if (res_zero !== 1'b0) begin bad++; $display("[TB] FAIL reset_res_zero: got %b want 0", res_zero); end
    total++; if (res_id !== '0) begin bad++; $display("[TB] FAIL reset_res_id: got %0d want 0", res_id); end
    total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL reset_ready_held: got %b want 0", req_ready); end
    req_valid = '0;
    rst_n = 1'b1;
    mptr = 0;
  endtask

  task automatic test_directed();
    int          tk[4]   = '{0, 1, 0, 1};
    logic [BW-1:0] ta[4] = '{11'h400, 11'h001, 11'h0F0, 11'h000};
    logic [BW-1:0] tb[4] = '{11'h400, 11'h001, 11'h00F, 11'h000};
    logic [BW:0] tv[4]   = '{12'hC00, 12'h003, 12'h0FF, 12'h000};
    logic [LW-1:0] tl[4] = '{4'd11, 4'd1, 4'd7, 4'd0};
    logic        tz[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] exp_rdy;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      req_a[tk[t]*BW +: BW] = ta[t];
      req_b[tk[t]*BW +: BW] = tb[t];
      req_valid = '0;
      req_valid[tk[t]] = 1'b1;
      res_ready = 1'b0;
      exp_rdy = '0;
      exp_rdy[tk[t]] = 1'b1;
      #1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL dir%0d_grant: got %b want %b", t, req_ready, exp_rdy); end
      mptr = (tk[t] + 1) % N;
      @(negedge clk);
      req_valid = '0;
      total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_calc_valid: got %b want 0", t, res_valid); end
      total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL dir%0d_calc_ready: got %b want 0", t, req_ready); end
      @(negedge clk);
      total++; if (res_valid !== 1'b1) begin bad++; $display("[TB] FAIL dir%0d_latency: res_valid got %b want 1", t, res_valid); end
      total++; if (res_vec !== tv[t]) begin bad++; $display("[TB] FAIL dir%0d_vec: got %h want %h", t, res_vec, tv[t]); end
      total++; if (res_lod !== tl[t]) begin bad++; $display("[TB] FAIL dir%0d_lod: got %0d want %0d", t, res_lod, tl[t]); end
      total++; if (res_zero !== tz[t]) begin bad++; $display("[TB] FAIL dir%0d_zero: got %b want %b", t, res_zero, tz[t]); end
      total++; if (res_id !== IDW'(tk[t])) begin bad++; $display("[TB] FAIL dir%0d_id: got %0d want %0d", t, res_id, tk[t]); end
      res_ready = 1'b1;
      @(negedge clk);
      total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_handshake: res_valid got %b want 0", t, res_valid); end
      res_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] da[N];
    logic [BW-1:0] db[N];
    logic [N-1:0]  exp_rdy;
    logic [BW:0]   ev;
    int            eid, g, acc, nacc, refresh;
    bit            busy, exp_valid;
    for (int k = 0; k < N; k++) begin
      da[k] = BW'($urandom); db[k] = BW'($urandom);
      req_a[k*BW +: BW] = da[k]; req_b[k*BW +: BW] = db[k];
    end
    busy = 0; acc = 0; nacc = 0; refresh = -1; ev = '0; eid = 0;
    for (int cyc = 0; cyc < 36; cyc++) begin
      @(negedge clk);
      req_valid = '1;
      res_ready = 1'b1;
      if (refresh >= 0) begin
        da[refresh] = BW'($urandom); db[refresh] = BW'($urandom);
        req_a[refresh*BW +: BW] = da[refresh]; req_b[refresh*BW +: BW] = db[refresh];
        refresh = -1;
      end
      #1;
      exp_valid = busy && (cyc - acc == 2);
      total++; if (res_valid !== exp_valid) begin bad++; $display("[TB] FAIL b2b_valid cyc%0d: got %b want %b", cyc, res_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (res_vec !== ev || res_id !== IDW'(eid) || res_lod !== model_lod(ev) || res_zero !== (ev == 0))
          begin bad++; $display("[TB] FAIL b2b_result cyc%0d: got vec=%h id=%0d lod=%0d want vec=%h id=%0d lod=%0d", cyc, res_vec, res_id, res_lod, ev, eid, model_lod(ev)); end
      end
      exp_rdy = '0;
      g = busy ? -1 : model_grant('1, mptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL b2b_grant cyc%0d: got %b want %b", cyc, req_ready, exp_rdy); end
      if (g >= 0) begin
        if (nacc > 0) begin
          total++; if (cyc - acc != 3) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d cycles want 3", cyc - acc); end
        end
        ev = model_vec(da[g], db[g]); eid = g;
        mptr = (g + 1) % N; acc = cyc; busy = 1; nacc++; refresh = g;
      end else if (exp_valid) begin
        busy = 0;
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [BW-1:0] da[N];
    logic [BW-1:0] db[N];
    logic [N-1:0]  vld, exp_rdy;
    logic [BW:0]   ev;
    int            waitcnt[N];
    int            eid, g, acc, drop;
    bit            busy, exp_valid;
    vld = '0; busy = 0; acc = 0; drop = -1; ev = '0; eid = 0;
    for (int k = 0; k < N; k++) begin waitcnt[k] = 0; da[k] = '0; db[k] = '0; end
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (drop >= 0) begin vld[drop] = 1'b0; drop = -1; end
      for (int k = 0; k < N; k++) begin
        if (!vld[k] && $urandom_range(0, 1) == 1) begin
          vld[k] = 1'b1; da[k] = BW'($urandom); db[k] = BW'($urandom);
          if ($urandom_range(0, 3) == 0) begin da[k] = '0; db[k] = '0; end
        end
        req_a[k*BW +: BW] = da[k]; req_b[k*BW +: BW] = db[k];
      end
      req_valid = vld;
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_valid = busy && (cyc - acc >= 2);
      total++; if (res_valid !== exp_valid) begin bad++; $display("[TB] FAIL rnd_valid cyc%0d: got %b want %b", cyc, res_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (res_vec !== ev || res_id !== IDW'(eid) || res_lod !== model_lod(ev) || res_zero !== (ev == 0))
          begin bad++; $display("[TB] FAIL rnd_result cyc%0d: got vec=%h id=%0d lod=%0d z=%b want vec=%h id=%0d lod=%0d", cyc, res_vec, res_id, res_lod, res_zero, ev, eid, model_lod(ev)); end
      end
      exp_rdy = '0;
      g = busy ? -1 : model_grant(vld, mptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL rnd_grant cyc%0d: got %b want %b", cyc, req_ready, exp_rdy); end
      if (g >= 0) begin
        total++; if (waitcnt[g] >= N) begin bad++; $display("[TB] FAIL rnd_fairness: req%0d waited %0d grants want <%0d", g, waitcnt[g], N); end
        for (int k = 0; k < N; k++) if (k != g && vld[k]) waitcnt[k]++;
        waitcnt[g] = 0;
        ev = model_vec(da[g], db[g]); eid = g;
        mptr = (g + 1) % N; acc = cyc; busy = 1; drop = g;
      end else if (exp_valid && res_ready) begin
        busy = 0;
      end
    end
    do_reset();
  endtask

  task automatic test_stall_reset();
    logic [BW:0] ev;
    ev = model_vec(11'h123, 11'h0F1);
    @(negedge clk);
    req_a[0 +: BW] = 11'h123; req_b[0 +: BW] = 11'h0F1;
    req_valid = 2'b01;
    res_ready = 1'b0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL stall_grant: got %b want 01", req_ready); end
    mptr = 1;
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      #1;
      total++; if (res_valid !== 1'b1 || res_vec !== ev || res_id !== 1'b0 || res_lod !== model_lod(ev))
        begin bad++; $display("[TB] FAIL stall_hold%0d: got v=%b vec=%h id=%0d lod=%0d want v=1 vec=%h id=0 lod=%0d", s, res_valid, res_vec, res_id, res_lod, ev, model_lod(ev)); end
      total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL stall_no_grant%0d: got %b want 0", s, req_ready); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL stall_rst_ready: got %b want 0", req_ready); end
    @(negedge clk);
    total++; if (res_valid !== 1'b0 || res_vec !== '0) begin bad++; $display("[TB] FAIL stall_rst_discard: got v=%b vec=%h want v=0 vec=0", res_valid, res_vec); end
    rst_n = 1'b1;
    mptr = 0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL stall_rst_ptr: got %b want 01", req_ready); end
    do_reset();
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    $display("[TB] starting lod_pred_arb bench");
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
